// File: rtl/bank_response_arbiter.sv
// Round-robin arbiter sharing one registered response channel among NUM_BANKS bank queues.
// Each accepted response is tagged with its bank index and the global_cycle of acceptance.
module bank_response_arbiter #(
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 32,
  parameter int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [63:0]                   global_cycle,
  input  logic [NUM_BANKS-1:0]          in_valid,
  output logic [NUM_BANKS-1:0]          in_ready,
  input  logic [NUM_BANKS*ADDR_W-1:0]   in_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]   in_data,
  input  logic [NUM_BANKS*ID_W-1:0]     in_id,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_W-1:0]             out_addr,
  output logic [DATA_W-1:0]             out_data,
  output logic [ID_W-1:0]               out_id,
  output logic [BANK_W-1:0]             out_bank,
  output logic [63:0]                   out_cycle,
  output logic [31:0]                   resp_count
);

  logic                 out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [ID_W-1:0]      out_id_q, out_id_d;
  logic [BANK_W-1:0]    out_bank_q, out_bank_d;
  logic [63:0]          out_cycle_q, out_cycle_d;
  logic [31:0]          resp_count_q, resp_count_d;
  logic [BANK_W-1:0]    last_grant_q, last_grant_d;

  logic                 load_en;
  logic                 found;
  logic [NUM_BANKS-1:0] grant_oh;
  logic [BANK_W-1:0]    grant_idx;
  int unsigned          idx;

  // Reset blocks the grant so no input handshake completes in the reset cycle.
  assign load_en = !reset && (!out_valid_q || out_ready);

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (load_en) begin
      for (int unsigned k = 1; k <= NUM_BANKS; k++) begin
        idx = (32'(last_grant_q) + k) % NUM_BANKS;
        if (!found && in_valid[idx]) begin
          found         = 1'b1;
          grant_oh[idx] = 1'b1;
          grant_idx     = BANK_W'(idx);
        end
      end
    end
  end

  assign in_ready = grant_oh;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    out_bank_d   = out_bank_q;
    out_cycle_d  = out_cycle_q;
    last_grant_d = last_grant_q;
    resp_count_d = resp_count_q;

    if (found) begin
      out_valid_d  = 1'b1;
      out_addr_d   = in_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
      out_data_d   = in_data[32'(grant_idx)*DATA_W +: DATA_W];
      out_id_d     = in_id[32'(grant_idx)*ID_W +: ID_W];
      out_bank_d   = grant_idx;
      out_cycle_d  = global_cycle;
      last_grant_d = grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (out_valid_q && out_ready && (resp_count_q != 32'hFFFF_FFFF)) begin
      resp_count_d = resp_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      out_bank_q   <= '0;
      out_cycle_q  <= '0;
      resp_count_q <= '0;
      last_grant_q <= BANK_W'(NUM_BANKS - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      out_bank_q   <= out_bank_d;
      out_cycle_q  <= out_cycle_d;
      resp_count_q <= resp_count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign out_bank   = out_bank_q;
  assign out_cycle  = out_cycle_q;
  assign resp_count = resp_count_q;

endmodule

// File: doc/bank_response_arbiter.md
Name: bank_response_arbiter

Overview:
- Round-robin arbiter that shares one response channel among NUM_BANKS per-bank response queues in the HBM controller.
- Each bank presents a valid/ready response carrying addr, data and request_id.
- The winner is latched into a single output register tagged with its bank index and the global_cycle of acceptance.
- The arbiter feeds the downstream response path and the per-bank response statistics loggers.

Parameters:
- NUM_BANKS, 8, number of requesting bank queues (>=1).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ID_W, 32, request_id width.
- BANK_W, max(1,$clog2(NUM_BANKS)), derived, width of the bank index.

Ports:
- clk  input  1  single clock, all state on posedge.
- reset  input  1  synchronous, active-high.
- global_cycle  input  64  free-running cycle count.
- in_valid  input  NUM_BANKS  per-bank response valid.
- in_ready  output  NUM_BANKS  per-bank accept (one-hot or zero).
- in_addr  input  NUM_BANKS*ADDR_W  flattened; bank i occupies bits [i*ADDR_W +: ADDR_W].
- in_data  input  NUM_BANKS*DATA_W  flattened, same packing.
- in_id  input  NUM_BANKS*ID_W  flattened, same packing.
- out_valid  output  1  output register holds a response.
- out_ready  input  1  downstream accept.
- out_addr  output  ADDR_W  registered payload.
- out_data  output  DATA_W  registered payload.
- out_id  output  ID_W  registered payload.
- out_bank  output  BANK_W  index of the granted bank.
- out_cycle  output  64  global_cycle sampled at acceptance.
- resp_count  output  32  total output handshakes.

Behaviour:
- Reset (sync, active-high) clears state. Outputs: out_valid=0; out_addr/data/id/bank/cycle=0; resp_count=0; in_ready=0. Internal last_grant=NUM_BANKS-1, so bank 0 has first priority.
- Reset mid-operation discards any held entry. No handshake completes in the reset cycle.
- Load enable: load_en = !out_valid || out_ready.
- Grant (combinational):
  - When load_en is high, scan banks starting at (last_grant+1) mod NUM_BANKS, wrapping.
  - The first bank with in_valid=1 wins, and only its in_ready bit is high.
  - No valid bank, or load_en low, gives in_ready=0.
- Input handshake: in_valid[i] && in_ready[i].
- On the input handshake clock edge:
  - Load bank i's addr/data/id into the output register.
  - out_bank=i, out_cycle=global_cycle of that cycle.
  - out_valid=1, last_grant=i.
- Latency: a response accepted in cycle T appears on the outputs in cycle T+1.
- Output handshake: out_valid && out_ready.
  - If a new grant occurs in the same cycle, the register reloads and out_valid stays 1. This gives full throughput of one response per cycle.
  - Otherwise out_valid goes to 0.
- Backpressure: while out_valid=1 and out_ready=0, all payload outputs hold stable and in_ready=0.
- last_grant changes only on a grant. Idle cycles do not move priority.
- Fairness: with all banks continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0. A bank waits at most NUM_BANKS-1 grants.
- resp_count increments by 1 on each output handshake and saturates at 0xFFFFFFFF.
- NUM_BANKS=1: the arbiter degenerates to a one-entry pipeline register; out_bank is always 0.
- in_valid dropping without a handshake is tolerated. Inputs are sampled only on the handshake.

Test Plan:
- Reset, then in_valid=0 for 5 cycles -> out_valid=0, in_ready=0, resp_count=0, all payloads 0.
- Single grant: bank 3 presents addr=0x100, data=0xAB, id=7 at global_cycle=20, out_ready=1 -> in_ready=8'b0000_1000 in cycle 20. Cycle 21: out_valid=1, out_bank=3, out_addr=0x100, out_data=0xAB, out_id=7, out_cycle=20. resp_count=1 after the handshake.
- Round-robin: all 8 banks valid continuously, out_ready=1 -> out_bank sequence 0,1,…,7,0,1 on consecutive cycles with no bubbles. resp_count=10 after 10 handshakes.
- Backpressure: out_ready=0 for 4 cycles while banks 1 and 2 are valid -> payload and out_bank frozen, in_ready=0 throughout. After release, the next grant follows last_grant+1.
- Priority wrap: last_grant=6, only banks 2 and 7 valid -> bank 7 granted, then bank 2.
- Reset mid-hold: out_valid=1 with out_ready=0, assert reset for 1 cycle -> out_valid=0 and resp_count=0 next cycle. The next grant with banks 0 and 5 valid goes to bank 0.
